// File: rtl/exp_coeff_seq.sv
// -----------------------------------------------------------------------------
// exp_coeff_seq
//
// Reads the Taylor coefficients 1/k! out of coeff_rom from a top index down to
// 0 and streams them to the floating-point Horner MAC. Each beat carries the
// coefficient index and a last flag. A 2-entry FIFO sits between the ROM and
// the MAC so that reads already issued always have somewhere to land when the
// MAC applies backpressure.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active HIGH (1 = reset)
//   start      in   begin a sequence (sampled only in IDLE)
//   num_terms  in   highest coefficient index wanted (sampled with start)
//   busy       out  a sequence is in progress (ISSUE or DRAIN)
//   done       out  one-cycle pulse after the last beat handshakes
//   rom_rd     out  ROM read strobe
//   rom_addr   out  ROM read address (0 whenever rom_rd is low)
//   rom_data   in   ROM data, valid the cycle after rom_rd
//   c_valid    out  coefficient beat valid
//   c_ready    in   MAC accepts the beat
//   c_data     out  coefficient value
//   c_idx      out  coefficient index k
//   c_last     out  high on the beat with c_idx == 0
//   dbg_state  out  current FSM state, for checkers
//
// Handshake: a beat transfers on every rising edge where c_valid && c_ready.
// Once c_valid is raised, c_data/c_idx/c_last stay unchanged and c_valid stays
// high until that transfer happens. c_ready may be driven without regard to
// c_valid.
//
// Timing: start accepted at edge E -> rom_rd in the cycle after E. A read
// issued in cycle t returns ROM data in t+1, which is written into the FIFO at
// the end of t+1, so the beat is presented from t+2. With c_ready held high
// the stream runs at one beat per cycle.
// -----------------------------------------------------------------------------
module exp_coeff_seq #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_COEFF  = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] num_terms,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_rd,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  c_valid,
  input  logic                  c_ready,
  output logic [DATA_WIDTH-1:0] c_data,
  output logic [ADDR_WIDTH-1:0] c_idx,
  output logic                  c_last,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] TOP_MAX = ADDR_WIDTH'(NUM_COEFF - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // One read can be in flight: the ROM answers the cycle after rom_rd.
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] inflight_idx_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [ADDR_WIDTH-1:0] fifo_idx_q  [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q;

  logic                  push, pop, credit, rd;
  logic [1:0]            occ_after;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_idx;

  assign push      = inflight_q;
  assign c_valid   = (count_q != 2'd0);
  assign pop       = c_valid & c_ready;
  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_idx  = fifo_idx_q[rd_ptr_q];

  // Credit counts buffer occupancy plus the read in flight, after this
  // cycle's pop. A read issued now lands next cycle, so it may only go out if
  // fewer than two entries will be held or owed; accounting for the pop keeps
  // the stream at full rate when the MAC is always ready.
  assign occ_after = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign credit    = (occ_after < 2'd2);
  assign rd        = (state_q == S_ISSUE) && credit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          cnt_d   = (num_terms > TOP_MAX) ? TOP_MAX : num_terms;
        end
      end
      S_ISSUE: begin
        if (rd) begin
          // Address 0 is the final read; the counter never goes below 0.
          if (cnt_q == '0) state_d = S_DRAIN;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (pop && c_last) state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd;
      if (rd) inflight_idx_q <= cnt_q;
    end
  end

  // 2-entry FIFO. Overflow cannot happen because reads are credit-limited.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= rom_data;
        fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Beat fields are forced to 0 when no beat is presented so idle outputs
  // are clean.
  assign c_data    = c_valid ? head_data : '0;
  assign c_idx     = c_valid ? head_idx  : '0;
  assign c_last    = c_valid && (head_idx == '0);

  assign rom_rd    = rd;
  assign rom_addr  = rd ? cnt_q : '0;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
